// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Latency WIDTH+1 cycles from the start edge; a start is accepted only when idle, and cancel has priority over start.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              bzero_q, bzero_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  logic              signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_next;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [W2-1:0]     div_next;
  logic [W2-1:0]     prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  // Operand magnitudes; the magnitude of the most-negative value is correct when read as unsigned.
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    mag_a     = a_neg ? (~a + 1'b1) : a;
    mag_b     = b_neg ? (~b + 1'b1) : b;
  end

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[W2-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + 1'b1) : acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    a_d       = a_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (write_hi) hi_d = in_data;
        if (write_lo) lo_d = in_data;
        if (start && !cancel) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (b == '0);
          a_d       = a;
          opnd_d    = op[1] ? mag_b : mag_a;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (bzero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      a_q       <= a_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

  logic        clk;
  logic        rst32, start32, cancel32, whi32, wlo32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, in32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        rst8, start8, cancel8, whi8, wlo8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, in8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
    .cancel(cancel32), .write_hi(whi32), .write_lo(wlo32), .in_data(in32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(cancel8), .write_hi(whi8), .write_lo(wlo8), .in_data(in8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op on the 32-bit unit and returns at the negedge of its done cycle.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(negedge clk);
    start32 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done32 && lat < 100) begin
      bcnt += int'(busy32);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op32_chk(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bcnt;
    run32(o, x, y, lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, {32'd0, hi32}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo32}, {32'd0, elo});
  endtask

  task automatic op8_chk(input string tag, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo);
    int lat;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_hi"}, 64'(hi8), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo8), 64'(elo));
  endtask

  initial begin
    int lat, bcnt, n, seen;
    rst32 = 1'b1; start32 = 1'b0; cancel32 = 1'b0; whi32 = 1'b0; wlo32 = 1'b0;
    op32 = 2'd0; a32 = '0; b32 = '0; in32 = '0;
    rst8 = 1'b1; start8 = 1'b0; cancel8 = 1'b0; whi8 = 1'b0; wlo8 = 1'b0;
    op8 = 2'd0; a8 = '0; b8 = '0; in8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;

    // MULTU all-ones squared, with busy width measured
    run32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy", 64'(bcnt), 64'd33);
    chk("multu_hi", 64'(hi32), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo32), 64'h1);
    chk("multu_busy_done", 64'(busy32), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done32), 64'd0);

    // Signed multiply, then back-to-back start in the done cycle
    op32_chk("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op32_chk("b2b_multu", 2'd1, 32'd3, 32'd7, 32'd0, 32'h15);

    op32_chk("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op32_chk("divu", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    op32_chk("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    op32_chk("divu_z", 2'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);

    // MTHI while idle
    @(negedge clk);
    whi32 = 1'b1; in32 = 32'hAAAA0000;
    @(negedge clk);
    whi32 = 1'b0;
    chk("mthi_hi", 64'(hi32), 64'hAAAA0000);
    chk("mthi_lo_kept", 64'(lo32), 64'hFFFFFFFF);

    // MTLO and a second start during a running op are both ignored
    start32 = 1'b1; op32 = 2'd1; a32 = 32'd2; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 100) begin
      if (n == 5) begin wlo32 = 1'b1; in32 = 32'h5555; end
      if (n == 6) wlo32 = 1'b0;
      if (n == 8) chk("mtlo_busy_ignored", 64'(lo32), 64'hFFFFFFFF);
      if (n == 10) begin start32 = 1'b1; op32 = 2'd1; a32 = 32'd9; b32 = 32'd9; end
      if (n == 11) start32 = 1'b0;
      if (n == 12) chk("hi_hold_busy", 64'(hi32), 64'hAAAA0000);
      @(negedge clk);
      n++;
    end
    chk("ign_lat", 64'(n), 64'd33);
    chk("ign_hi", 64'(hi32), 64'd0);
    chk("ign_lo", 64'(lo32), 64'd6);

    // Cancel at cycle 12 of a DIVU
    start32 = 1'b1; op32 = 2'd3; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (12) @(negedge clk);
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    chk("cancel_busy", 64'(busy32), 64'd0);
    chk("cancel_done", 64'(done32), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(done32);
    end
    chk("cancel_no_done", 64'(seen), 64'd0);
    chk("cancel_hi", 64'(hi32), 64'd0);
    chk("cancel_lo", 64'(lo32), 64'd6);

    // Cancel beats start while idle
    start32 = 1'b1; cancel32 = 1'b1; op32 = 2'd1; a32 = 32'd1; b32 = 32'd1;
    @(negedge clk);
    start32 = 1'b0; cancel32 = 1'b0;
    chk("cancel_vs_start", 64'(busy32), 64'd0);

    // Reset mid-MULT, then a fresh op
    start32 = 1'b1; op32 = 2'd0; a32 = 32'd5; b32 = 32'd6;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    rst32 = 1'b1;
    @(negedge clk);
    chk("mrst_hi", 64'(hi32), 64'd0);
    chk("mrst_lo", 64'(lo32), 64'd0);
    chk("mrst_busy", 64'(busy32), 64'd0);
    chk("mrst_done", 64'(done32), 64'd0);
    rst32 = 1'b0;
    op32_chk("post_rst", 2'd0, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFF1);

    // Narrow instance
    op8_chk("w8_mult", 2'd0, 8'h80, 8'h80, 8'h40, 8'h00);
    op8_chk("w8_div", 2'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
